// File: rtl/cla_pipe_adder_if.sv
// rtl/cla_pipe_adder_if.sv - operand/result handshake bundle for the pipelined CLA adder
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - two-stage carry-lookahead adder with valid/ready on both sides
module cla_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  cla_pipe_adder_if.slave  bus
);
  localparam int NIB = WIDTH / 4;

  // Carries into bits 0..3 of one nibble, given its carry-in.
  function automatic logic [3:0] nib_carries(input logic [3:0] p, input logic [3:0] g,
                                             input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  function automatic logic nib_gen(input logic [3:0] p, input logic [3:0] g);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_x;
  logic             s1_cin;
  logic [NIB-1:0]   s1_gp;
  logic [NIB-1:0]   s1_gg;

  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic             s1_en;
  logic             s2_en;

  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] g_d;
  logic [WIDTH-1:0] x_d;
  logic [NIB-1:0]   gp_d;
  logic [NIB-1:0]   gg_d;

  logic [WIDTH-1:0] c_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  // Ready depends only on out_ready and pipeline state, never on in_valid.
  assign s2_en        = !out_valid_r | bus.out_ready;
  assign s1_en        = !s1_valid | s2_en;
  assign bus.in_ready = s1_en;

  always_comb begin
    p_d  = bus.a | bus.b;
    g_d  = bus.a & bus.b;
    x_d  = bus.a ^ bus.b;
    gp_d = '0;
    gg_d = '0;
    for (int k = 0; k < NIB; k++) begin
      gp_d[k] = &p_d[4*k +: 4];
      gg_d[k] = nib_gen(p_d[4*k +: 4], g_d[4*k +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_x     <= '0;
      s1_cin   <= 1'b0;
      s1_gp    <= '0;
      s1_gg    <= '0;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      s1_p     <= p_d;
      s1_g     <= g_d;
      s1_x     <= x_d;
      s1_cin   <= bus.cin;
      s1_gp    <= gp_d;
      s1_gg    <= gg_d;
    end
  end

  // Nibble carry chain on group terms, then per-bit lookahead inside each nibble.
  always_comb begin
    logic carry;
    c_d   = '0;
    carry = s1_cin;
    for (int k = 0; k < NIB; k++) begin
      c_d[4*k +: 4] = nib_carries(s1_p[4*k +: 4], s1_g[4*k +: 4], carry);
      carry         = s1_gg[k] | (s1_gp[k] & carry);
    end
    cout_d = carry;
    sum_d  = s1_x ^ c_d;
    ovf_d  = c_d[WIDTH-1] ^ cout_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (s2_en) begin
      out_valid_r <= s1_valid;
      sum_r       <= sum_d;
      cout_r      <= cout_d;
      ovf_r       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - directed-vector bench for cla_pipe_adder
module tb_cla_pipe_adder;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vt[15];
  int   q[$];

  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(16)) bus ();

  cla_pipe_adder #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load(input int i);
    bus.a   = vt[i].a;
    bus.b   = vt[i].b;
    bus.cin = vt[i].cin;
  endtask

  task automatic check_out(input string tag, input int i);
    check({tag, "_sum"},  32'(bus.sum),  32'(vt[i].s));
    check({tag, "_cout"}, 32'(bus.cout), 32'(vt[i].co));
    check({tag, "_ovf"},  32'(bus.ovf),  32'(vt[i].ov));
  endtask

  // Single vector into an empty pipe: result appears exactly two cycles after presentation.
  task automatic latency_check(input string tag, input int i);
    @(posedge clk); #1;
    load(i);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_ov_t0"},    32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_ov_t1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_ov_t2"}, 32'(bus.out_valid), 32'd1);
    check_out(tag, i);
    @(negedge clk);
    check({tag, "_ov_t3"}, 32'(bus.out_valid), 32'd0);
  endtask

  // mode 0: out_ready always 1; mode 1: stalled for 5 cycles then 1; mode 2: random out_ready.
  task automatic run_stream(input string tag, input int first, input int n, input int mode);
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    int          run = 0;
    int          maxrun = 0;
    int          idx;
    logic        held = 1'b0;
    logic [17:0] held_v = '0;
    @(posedge clk); #1;
    load(first);
    bus.in_valid  = 1'b1;
    bus.out_ready = (mode == 1) ? 1'b0 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (got < n && cyc < 300) begin
      @(negedge clk);
      if (held && bus.out_valid)
        check({tag, "_stable"}, 32'({bus.cout, bus.ovf, bus.sum}), 32'(held_v));
      held   = bus.out_valid && !bus.out_ready;
      held_v = {bus.cout, bus.ovf, bus.sum};
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check({tag, "_spurious"}, 32'd1, 32'd0);
        end else begin
          idx = q.pop_front();
          check_out(tag, idx);
        end
        got++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(first + sent);
        sent++;
      end
      if (mode == 1 && cyc == 4) begin
        check({tag, "_accepts"},  32'(sent), 32'd2);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
      bus.in_valid = (sent < n);
      if (sent < n) load(first + sent);
      bus.out_ready = (mode == 1) ? (cyc >= 5) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check({tag, "_count"}, 32'(got), 32'(n));
    check({tag, "_drained"}, 32'(q.size()), 32'd0);
    if (mode == 0) check({tag, "_consecutive"}, 32'(maxrun), 32'(n));
    q.delete();
  endtask

  initial begin
    vt[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[2]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[4]  = '{16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0};
    vt[5]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[6]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[7]  = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
    vt[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[9]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vt[10] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vt[11] = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[12] = '{16'h7000, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[13] = '{16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b0};
    vt[14] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    latency_check("lat", 0);
    latency_check("ripple", 1);
    latency_check("ovf_pos", 2);
    latency_check("ovf_neg", 3);

    run_stream("b2b", 4, 4, 0);
    run_stream("stall", 8, 6, 1);

    // Two results in flight, then an asynchronous reset away from any clock edge.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    load(5);
    @(posedge clk); #1;
    load(6);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2;
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_in_ready",  32'(bus.in_ready),  32'd0);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_sum",       32'(bus.sum),       32'd0);
    check("async_rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    latency_check("post_rst", 7);

    for (int r = 0; r < 4; r++) run_stream("rand", 0, 15, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
